// File: rtl/convert_rgb_to_hsv_param.sv
// Frame RGB->HSV pass: per pixel ADDR, LOAD, 2*CHAN_W divide cycles, WRITE (3 cycles when achromatic).
// pause freezes all state including a pending write strobe; enable low aborts the pass to IDLE.
module convert_rgb_to_hsv_param #(
    parameter int                  CHAN_W       = 8,
    parameter int                  IMAGE_WIDTH  = 320,
    parameter int                  IMAGE_HEIGHT = 240,
    parameter int                  ADDR_W       = 18,
    parameter int                  SRC_OFFSET   = IMAGE_WIDTH * IMAGE_HEIGHT + 1,
    parameter int                  DST_OFFSET   = 2 * IMAGE_WIDTH * IMAGE_HEIGHT + 2,
    parameter logic [4*CHAN_W-1:0] STORE_MASK   = '1,
    parameter logic [CHAN_W-1:0]   NO_HUE       = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                pause,
    input  logic                mode,
    input  logic [CHAN_W-1:0]   hue_lo,
    input  logic [CHAN_W-1:0]   hue_hi,
    input  logic [CHAN_W-1:0]   sat_min,
    input  logic [CHAN_W-1:0]   val_min,
    input  logic [4*CHAN_W-1:0] data_read,
    output logic [ADDR_W-1:0]   address,
    output logic                wren,
    output logic [4*CHAN_W-1:0] data_write,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   achromatic_count
);

    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int QW    = 2 * CHAN_W;
    localparam int HW    = 2 * CHAN_W + 3;
    localparam int CNT_W = $clog2(2 * CHAN_W);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_DIV, S_WRITE, S_DONE} state_t;

    state_t              state;
    logic                mode_q;
    logic [ADDR_W-1:0]   pix_cnt;
    logic [CHAN_W-1:0]   v_q;
    logic [1:0]          hue_sel;
    logic                hue_sub;
    logic [CNT_W-1:0]    div_cnt;
    logic [QW-1:0]       s_dvd, s_q, h_dvd, h_q;
    logic [CHAN_W-1:0]   s_rem, s_dvs, h_rem, h_dvs;

    logic [CHAN_W-1:0]   r_in, g_in, b_in;
    logic [CHAN_W-1:0]   mx, mn, delta, diff_abs;
    logic                diff_neg;
    logic [1:0]          max_sel;

    logic [CHAN_W:0]     s_trial, s_diff, h_trial, h_diff;
    logic                s_ge, h_ge;
    logic [CHAN_W-1:0]   s_rem_nx, h_rem_nx;
    logic [QW-1:0]       s_q_nx, h_q_nx;
    logic [HW-1:0]       hue_base, hue_raw;
    logic [CHAN_W-1:0]   h_val, s_sat;
    logic [4*CHAN_W-1:0] chrom_word, achrom_word;
    logic                unused_bits;

    assign r_in = data_read[CHAN_W-1:0];
    assign g_in = data_read[2*CHAN_W-1:CHAN_W];
    assign b_in = data_read[4*CHAN_W-1:3*CHAN_W];

    function automatic logic [4*CHAN_W-1:0] build_word(
        input logic [CHAN_W-1:0] h, input logic [CHAN_W-1:0] s, input logic [CHAN_W-1:0] v,
        input logic achrom, input logic msk_mode,
        input logic [CHAN_W-1:0] lo, input logic [CHAN_W-1:0] hi,
        input logic [CHAN_W-1:0] smin, input logic [CHAN_W-1:0] vmin);
        logic band;
        band = (lo <= hi) ? (h >= lo && h <= hi) : (h >= lo || h <= hi);
        if (msk_mode)
            build_word = (!achrom && band && s >= smin && v >= vmin) ? '1 : '0;
        else
            build_word = {h, {CHAN_W{1'b0}}, s, v} & STORE_MASK;
    endfunction

    // Max priority r > g > b on ties; diff is the hue numerator for the max channel.
    always_comb begin
        max_sel  = 2'd0;
        mx       = r_in;
        diff_neg = 1'b0;
        diff_abs = '0;
        if (r_in >= g_in && r_in >= b_in) begin
            mx       = r_in;
            diff_neg = g_in < b_in;
            diff_abs = diff_neg ? b_in - g_in : g_in - b_in;
        end else if (g_in >= b_in) begin
            max_sel  = 2'd1;
            mx       = g_in;
            diff_neg = b_in < r_in;
            diff_abs = diff_neg ? r_in - b_in : b_in - r_in;
        end else begin
            max_sel  = 2'd2;
            mx       = b_in;
            diff_neg = r_in < g_in;
            diff_abs = diff_neg ? g_in - r_in : r_in - g_in;
        end
        mn = r_in;
        if (g_in < mn) mn = g_in;
        if (b_in < mn) mn = b_in;
        delta = mx - mn;
    end

    // One restoring-division step for each divider; remainder stays below the divisor.
    always_comb begin
        s_trial  = {s_rem, s_dvd[QW-1]};
        s_diff   = s_trial - {1'b0, s_dvs};
        s_ge     = s_trial >= {1'b0, s_dvs};
        s_rem_nx = s_ge ? s_diff[CHAN_W-1:0] : s_trial[CHAN_W-1:0];
        s_q_nx   = {s_q[QW-2:0], s_ge};
        h_trial  = {h_rem, h_dvd[QW-1]};
        h_diff   = h_trial - {1'b0, h_dvs};
        h_ge     = h_trial >= {1'b0, h_dvs};
        h_rem_nx = h_ge ? h_diff[CHAN_W-1:0] : h_trial[CHAN_W-1:0];
        h_q_nx   = {h_q[QW-2:0], h_ge};
    end

    always_comb begin
        case (hue_sel)
            2'd0:    hue_base = hue_sub ? (HW'(6) << CHAN_W) : '0;
            2'd1:    hue_base = HW'(2) << CHAN_W;
            default: hue_base = HW'(4) << CHAN_W;
        endcase
        hue_raw     = hue_sub ? hue_base - HW'(h_q_nx) : hue_base + HW'(h_q_nx);
        h_val       = hue_raw[CHAN_W+2:3];
        s_sat       = (|s_q_nx[QW-1:CHAN_W]) ? '1 : s_q_nx[CHAN_W-1:0];
        chrom_word  = build_word(h_val, s_sat, v_q, 1'b0, mode_q, hue_lo, hue_hi, sat_min, val_min);
        achrom_word = build_word(NO_HUE, '0, mx, 1'b1, mode_q, hue_lo, hue_hi, sat_min, val_min);
    end

    assign unused_bits = ^{data_read[3*CHAN_W-1:2*CHAN_W], hue_raw[HW-1:CHAN_W+3], hue_raw[2:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            address          <= '0;
            wren             <= 1'b0;
            data_write       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            achromatic_count <= '0;
            pix_cnt          <= '0;
            mode_q           <= 1'b0;
            v_q              <= '0;
            hue_sel          <= 2'd0;
            hue_sub          <= 1'b0;
            div_cnt          <= '0;
            s_dvd <= '0; s_q <= '0; s_rem <= '0; s_dvs <= '0;
            h_dvd <= '0; h_q <= '0; h_rem <= '0; h_dvs <= '0;
        end else if (!pause) begin
            if (!enable) begin
                state <= S_IDLE;
                wren  <= 1'b0;
                done  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state            <= S_ADDR;
                        mode_q           <= mode;
                        pix_cnt          <= '0;
                        achromatic_count <= '0;
                        busy             <= 1'b1;
                        wren             <= 1'b0;
                        address          <= ADDR_W'(SRC_OFFSET);
                    end
                    S_ADDR: state <= S_LOAD;
                    S_LOAD: begin
                        v_q     <= mx;
                        hue_sel <= max_sel;
                        hue_sub <= diff_neg;
                        if (delta == '0) begin
                            achromatic_count <= achromatic_count + 1'b1;
                            data_write       <= achrom_word;
                            address          <= ADDR_W'(DST_OFFSET) + pix_cnt;
                            wren             <= 1'b1;
                            state            <= S_WRITE;
                        end else begin
                            s_dvd   <= {delta, {CHAN_W{1'b0}}};
                            s_dvs   <= mx;
                            s_rem   <= '0;
                            s_q     <= '0;
                            h_dvd   <= {diff_abs, {CHAN_W{1'b0}}};
                            h_dvs   <= delta;
                            h_rem   <= '0;
                            h_q     <= '0;
                            div_cnt <= '0;
                            state   <= S_DIV;
                        end
                    end
                    S_DIV: begin
                        s_dvd   <= s_dvd << 1;
                        s_rem   <= s_rem_nx;
                        s_q     <= s_q_nx;
                        h_dvd   <= h_dvd << 1;
                        h_rem   <= h_rem_nx;
                        h_q     <= h_q_nx;
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == CNT_W'(2 * CHAN_W - 1)) begin
                            data_write <= chrom_word;
                            address    <= ADDR_W'(DST_OFFSET) + pix_cnt;
                            wren       <= 1'b1;
                            state      <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        wren    <= 1'b0;
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == ADDR_W'(NPIX - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_ADDR;
                            address <= ADDR_W'(SRC_OFFSET) + pix_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_DONE;
                        wren  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
